// File: rtl/led_mux_disp.sv
// led_mux_disp: time-multiplexed 7-segment driver with prescaled scan,
// frame-latched inputs, leading-zero blanking and anti-ghosting blank time.
module led_mux_disp #(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYC      = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] data,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   en,
   input  logic                lzb,
   output logic [6:0]          seg,
   output logic                dp_o,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic                r_load_pend;
   logic [4*DIGITS-1:0] r_data_sh;
   logic [DIGITS-1:0]   r_dp_sh;
   logic [DIGITS-1:0]   r_en_sh;
   logic                r_lzb_sh;
   logic [6:0]          r_seg;
   logic                r_dp_o;
   logic [DIGITS-1:0]   r_an;
   logic                r_frame_done;

   logic                w_tick;
   logic                w_frame_end;
   logic                w_past_blank;
   logic [3:0]          w_nib;
   logic                w_dp_sel;
   logic                w_en_sel;
   logic                w_hz;
   logic                w_lz_blank;
   logic [DIGITS-1:0]   w_an_sel;
   logic                w_on;
   logic [6:0]          w_glyph;
   logic [6:0]          w_seg_nx;
   logic                w_dp_nx;
   logic [DIGITS-1:0]   w_an_nx;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h7E;
         4'h1: g = 7'h30;
         4'h2: g = 7'h6D;
         4'h3: g = 7'h79;
         4'h4: g = 7'h33;
         4'h5: g = 7'h5B;
         4'h6: g = 7'h5F;
         4'h7: g = 7'h72;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h7B;
         4'hA: g = 7'h77;
         4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;
         4'hD: g = 7'h3D;
         4'hE: g = 7'h4F;
         default: g = 7'h47;
      endcase
      return g;
   endfunction

   assign w_tick      = (r_cnt == CNT_LAST);
   assign w_frame_end = w_tick && (r_idx == IDX_LAST);

   generate
      if (BLANK_CYC == 0) begin : g_noblank
         assign w_past_blank = 1'b1;
      end else begin : g_blank
         assign w_past_blank = (r_cnt >= CW'(BLANK_CYC));
      end
   endgenerate

   // Prescaler, digit index and post-reset load request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_load_pend <= 1'b1;
      end else begin
         r_load_pend <= 1'b0;
         r_cnt       <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_tick)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
   end

   // Frame-latched copies of the inputs; only these drive the display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_sh <= '0;
         r_dp_sh   <= '0;
         r_en_sh   <= '0;
         r_lzb_sh  <= 1'b0;
      end else if (r_load_pend || w_frame_end) begin
         r_data_sh <= data;
         r_dp_sh   <= dp;
         r_en_sh   <= en;
         r_lzb_sh  <= lzb;
      end
   end

   // Select current digit and decide leading-zero blanking (scan from top)
   always_comb begin
      w_nib      = 4'h0;
      w_dp_sel   = 1'b0;
      w_en_sel   = 1'b0;
      w_hz       = 1'b1;
      w_lz_blank = 1'b0;
      w_an_sel   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_hz = w_hz && (r_data_sh[4*i +: 4] == 4'h0);
         if (r_idx == IW'(i)) begin
            w_nib       = r_data_sh[4*i +: 4];
            w_dp_sel    = r_dp_sh[i];
            w_en_sel    = r_en_sh[i];
            w_an_sel[i] = 1'b1;
            w_lz_blank  = r_lzb_sh && (i != 0) && w_hz;
         end
      end
   end

   // Next output values in board polarity
   always_comb begin
      w_on     = w_past_blank && w_en_sel;
      w_glyph  = (w_on && !w_lz_blank) ? glyph(w_nib) : 7'h00;
      w_seg_nx = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
      w_dp_nx  = (w_on && w_dp_sel) ^ SEG_ACTIVE_LOW;
      w_an_nx  = (w_on ? w_an_sel : '0) ^ AN_OFF;
   end

   // Registered pin drivers and frame pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg        <= SEG_OFF;
         r_dp_o       <= SEG_ACTIVE_LOW;
         r_an         <= AN_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nx;
         r_dp_o       <= w_dp_nx;
         r_an         <= w_an_nx;
         r_frame_done <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign dp_o       = r_dp_o;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule
